// File: rtl/seg7_scan_driver.sv
// Double-buffered, guard-interval scanned driver for common-anode 7-segment digits.
// Define SEG7_LZ_SUPPRESS_EN to enable leading-zero suppression.
module seg7_scan_driver #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blank,
    input  logic                load,
    output logic [6:0]          a2g,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     I_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0]     G_LIM  = PW'(GUARD);
    localparam logic [DIGITS-1:0] ONE    = DIGITS'(1);

    if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
        $error("seg7_scan_driver: DIGITS must be in 1..16");
    end
    if (GUARD < 0) begin : g_bad_guard
        $error("seg7_scan_driver: GUARD must be >= 0");
    end
    if (REFRESH_DIV < GUARD + 1) begin : g_bad_div
        $error("seg7_scan_driver: REFRESH_DIV must be >= GUARD+1");
    end

    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PW-1:0]       prescaler;
    logic [IW-1:0]       idx;
    logic                pending;
    logic [4*DIGITS-1:0] pend_data;
    logic [4*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   pend_blank;
    logic [DIGITS-1:0]   act_blank;
    logic                slot_end;
    logic                frame_end;

    assign slot_end  = (prescaler == P_LAST);
    assign frame_end = slot_end && (idx == I_LAST);

    // Active buffer only ever changes on the frame boundary edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
        end else begin
            prescaler <= slot_end ? '0 : prescaler + 1'b1;
            if (slot_end) begin
                idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
            end
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_in;
                pend_blank <= blank;
                pending    <= 1'b1;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (load) begin
                    act_data  <= data;
                    act_dp    <= dp_in;
                    act_blank <= blank;
                end else if (pending) begin
                    act_data  <= pend_data;
                    act_dp    <= pend_dp;
                    act_blank <= pend_blank;
                end
            end
        end
    end

    logic [3:0] nib;
    logic       in_guard;

    assign nib      = act_data[{idx, 2'b00} +: 4];
    assign in_guard = (GUARD > 0) && (prescaler < G_LIM);

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] sup;

    // Zeros above the most significant non-zero nibble are suppressed.
    always_comb begin
        logic seen;
        seen = 1'b0;
        sup  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (act_data[4*i +: 4] != 4'h0) seen = 1'b1;
            sup[i] = ~seen;
        end
    end
`endif

    logic [DIGITS-1:0] an_nx;
    logic [6:0]        seg_nx;
    logic              dp_nx;

    always_comb begin
        an_nx  = '1;
        seg_nx = 7'h7F;
        dp_nx  = 1'b1;
        if (!in_guard && !act_blank[idx]) begin
`ifdef SEG7_LZ_SUPPRESS_EN
            if (sup[idx]) begin
                if (act_dp[idx]) begin
                    an_nx = ~(ONE << idx);
                    dp_nx = 1'b0;
                end
            end else
`endif
            begin
                an_nx  = ~(ONE << idx);
                seg_nx = seg(nib);
                dp_nx  = ~act_dp[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            a2g        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nx;
            a2g        <= seg_nx;
            dp         <= dp_nx;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle scoreboard plus directed per-digit frame checks.
// Follows SEG7_LZ_SUPPRESS_EN to pick the expected suppression behaviour.
module tb_seg7_scan_driver;

    localparam int DIG = 4;
    localparam int RD  = 4;
    localparam int G   = 1;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] data  = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  a2g;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    seg7_scan_driver #(
        .DIGITS     (DIG),
        .REFRESH_DIV(RD),
        .GUARD      (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .dp_in     (dp_in),
        .blank     (blank),
        .load      (load),
        .a2g       (a2g),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          m_p;
    int          m_i;
    bit          m_pend;
    logic [15:0] m_pdata, m_adata;
    logic [3:0]  m_pdp, m_adp, m_pbl, m_abl;
    logic [12:0] q[$];

    function automatic logic [12:0] model_out();
        logic       fd;
        logic [3:0] nib;
        int         top;
        fd = (m_p == RD - 1) && (m_i == DIG - 1);
        if (m_p < G || m_abl[m_i]) return {4'hF, 7'h7F, 1'b1, fd};
        nib = m_adata[4*m_i +: 4];
`ifdef SEG7_LZ_SUPPRESS_EN
        top = 0;
        for (int k = 0; k < DIG; k++)
            if (m_adata[4*k +: 4] != 4'h0) top = k;
        if (m_i > top) begin
            if (m_adp[m_i])
                return {~(4'b0001 << m_i), 7'h7F, 1'b0, fd};
            return {4'hF, 7'h7F, 1'b1, fd};
        end
`else
        top = 0;
`endif
        return {~(4'b0001 << m_i), SEG[nib], ~m_adp[m_i], fd};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p     <= 0;
            m_i     <= 0;
            m_pend  <= 1'b0;
            m_pdata <= '0;
            m_pdp   <= '0;
            m_pbl   <= '1;
            m_adata <= '0;
            m_adp   <= '0;
            m_abl   <= '1;
            q.delete();
        end else begin
            q.push_back(model_out());
            m_p <= (m_p == RD - 1) ? 0 : m_p + 1;
            if (m_p == RD - 1) m_i <= (m_i + 1) % DIG;
            if (load) begin
                m_pdata <= data;
                m_pdp   <= dp_in;
                m_pbl   <= blank;
            end
            if (m_p == RD - 1 && m_i == DIG - 1) begin
                m_pend <= 1'b0;
                if (load) begin
                    m_adata <= data;
                    m_adp   <= dp_in;
                    m_abl   <= blank;
                end else if (m_pend) begin
                    m_adata <= m_pdata;
                    m_adp   <= m_pdp;
                    m_abl   <= m_pbl;
                end
            end else if (load) begin
                m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin : sb_check
        logic [12:0] e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            n_assert++;
            assert ({an, a2g, dp, frame_done} === e) else begin
                n_fail++;
                $error("FAIL scoreboard: got %h expected %h",
                       {an, a2g, dp, frame_done}, e);
            end
        end
    end

    task automatic wait_fd(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        chk({tag, " frame_done seen"}, 32'(frame_done), 32'd1);
    endtask

    // Entered on a frame_done negedge; leaves on the next one.
    task automatic check_frame(input string tag, input logic [15:0] e_an,
                               input logic [27:0] e_seg, input logic [3:0] e_dp);
        for (int d = 0; d < DIG; d++) begin
            @(negedge clk);
            chk($sformatf("%s d%0d guard an", tag, d), 32'(an), 32'hF);
            @(negedge clk);
            chk($sformatf("%s d%0d an", tag, d), 32'(an), 32'(e_an[4*d +: 4]));
            chk($sformatf("%s d%0d a2g", tag, d), 32'(a2g), 32'(e_seg[7*d +: 7]));
            chk($sformatf("%s d%0d dp", tag, d), 32'(dp), 32'(e_dp[d]));
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p,
                             input logic [3:0] b);
        data  = d;
        dp_in = p;
        blank = b;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset an", 32'(an), 32'hF);
        chk("reset a2g", 32'(a2g), 32'h7F);
        chk("reset dp", 32'(dp), 32'd1);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // No load: dark display, frame_done every DIG*RD cycles
        wait_fd("t1 first", n);
        for (int k = 0; k < 3; k++) begin
            wait_fd("t1", n);
            chk($sformatf("t1 frame period %0d", k), 32'(n), 32'd16);
        end
        check_frame("t1", 16'hFFFF, {4{7'h7F}}, 4'hF);

        // Mid-frame load committed at next boundary
        load_word(16'h1234, 4'h0, 4'h0);
        wait_fd("t2", n);
        check_frame("t2", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

        // Two loads in one frame: last wins, single frame_done
        repeat (2) @(negedge clk);
        load_word(16'hAAAA, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        load_word(16'h00F0, 4'h0, 4'h0);
        wait_fd("t3", n);
        chk("t3 one frame_done per frame", 32'(n), 32'd10);
`ifdef SEG7_LZ_SUPPRESS_EN
        check_frame("t3", 16'hFFDE, {7'h7F, 7'h7F, 7'h0E, 7'h40}, 4'hF);
`else
        check_frame("t3", 16'h7BDE, {7'h40, 7'h40, 7'h0E, 7'h40}, 4'hF);
`endif

        // Load on the boundary cycle overrides pending, no lag
        repeat (3) @(negedge clk);
        load_word(16'h1111, 4'h0, 4'h0);
        repeat (11) @(negedge clk);
        data  = 16'hBEEF;
        dp_in = 4'h0;
        blank = 4'h0;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        chk("t4 boundary frame_done", 32'(frame_done), 32'd1);
        check_frame("t4", 16'h7BDE, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF);

        // Blank and decimal point
        load_word(16'h1234, 4'b0001, 4'b0010);
        wait_fd("t5", n);
        check_frame("t5", 16'h7BFE, {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1110);

        // Leading zeros
        load_word(16'h0050, 4'h0, 4'h0);
        wait_fd("t6a", n);
`ifdef SEG7_LZ_SUPPRESS_EN
        check_frame("t6a", 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
`else
        check_frame("t6a", 16'h7BDE, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF);
`endif
        load_word(16'h0005, 4'b0100, 4'h0);
        wait_fd("t6b", n);
`ifdef SEG7_LZ_SUPPRESS_EN
        check_frame("t6b", 16'hFBFE, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1011);
`else
        check_frame("t6b", 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1011);
`endif

        // Asynchronous reset mid-slot
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7 async an", 32'(an), 32'hF);
        chk("t7 async a2g", 32'(a2g), 32'h7F);
        chk("t7 async dp", 32'(dp), 32'd1);
        chk("t7 async frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fd("t7", n);
        check_frame("t7 dark", 16'hFFFF, {4{7'h7F}}, 4'hF);
        wait_fd("t7 period", n);
        chk("t7 frame period", 32'(n), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
